// File: rtl/l1_msg_pkg.sv
// Shared message codes, FSM state encoding and line-width helper for the
// L1 cache <-> memory bus adapter.
package l1_msg_pkg;

  localparam logic [3:0] NO_REQ     = 4'd0;
  localparam logic [3:0] R_REQ      = 4'd1;
  localparam logic [3:0] WB_REQ     = 4'd2;
  localparam logic [3:0] FLUSH_REQ  = 4'd3;
  localparam logic [3:0] MEM_NO_MSG = 4'd0;
  localparam logic [3:0] MEM_RESP   = 4'd4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_RESP = 3'd2,
    RESPOND   = 3'd3,
    RELEASE   = 3'd4
  } state_t;

  function automatic int cache_width(input int data_width, input int offset_bits);
    return data_width << offset_bits;
  endfunction

endpackage

// File: rtl/l1_mem_bus_adapter.sv
// Bridges the L1 cache message port to a single-beat valid/ready line port.
// Optional perf counters are built when L1_MEM_BUS_ADAPTER_PERF_EN is defined.
//
// state     | meaning
// IDLE      | sampling cache2mem_msg for a new request
// ISSUE     | request beat valid, waiting for mem_req_ready
// WAIT_RESP | beat accepted, waiting for the mem_resp_valid pulse
// RESPOND   | MEM_RESP presented until the cache drops to NO_REQ
// RELEASE   | one cycle of MEM_NO_MSG before returning to IDLE
module l1_mem_bus_adapter
  import l1_msg_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int CACHE_OFFSET_BITS = 2,
  parameter int ADDRESS_BITS      = 32,
  parameter int MSG_BITS          = 4,
  localparam int CACHE_WIDTH      = cache_width(DATA_WIDTH, CACHE_OFFSET_BITS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [MSG_BITS-1:0]     cache2mem_msg,
  input  logic [ADDRESS_BITS-1:0] cache2mem_address,
  input  logic [CACHE_WIDTH-1:0]  cache2mem_data,
  output logic [MSG_BITS-1:0]     mem2cache_msg,
  output logic [ADDRESS_BITS-1:0] mem2cache_address,
  output logic [CACHE_WIDTH-1:0]  mem2cache_data,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_write,
  output logic [ADDRESS_BITS-1:0] mem_req_address,
  output logic [CACHE_WIDTH-1:0]  mem_req_data,
  input  logic                    mem_resp_valid,
  input  logic [CACHE_WIDTH-1:0]  mem_resp_data
`ifdef L1_MEM_BUS_ADAPTER_PERF_EN
  ,
  output logic [31:0]             perf_reads,
  output logic [31:0]             perf_writes
`endif
);

  localparam int OFF_BITS = CACHE_OFFSET_BITS + $clog2(DATA_WIDTH / 8);
  localparam logic [ADDRESS_BITS-1:0] ADDR_MASK =
    ~((ADDRESS_BITS'(1) << OFF_BITS) - ADDRESS_BITS'(1));

  localparam logic [MSG_BITS-1:0] M_NO_REQ   = MSG_BITS'(NO_REQ);
  localparam logic [MSG_BITS-1:0] M_R_REQ    = MSG_BITS'(R_REQ);
  localparam logic [MSG_BITS-1:0] M_WB_REQ   = MSG_BITS'(WB_REQ);
  localparam logic [MSG_BITS-1:0] M_FLUSH    = MSG_BITS'(FLUSH_REQ);
  localparam logic [MSG_BITS-1:0] M_NO_MSG   = MSG_BITS'(MEM_NO_MSG);
  localparam logic [MSG_BITS-1:0] M_RESP     = MSG_BITS'(MEM_RESP);

  state_t                  state_q, state_d;
  logic                    req_valid_q, req_valid_d;
  logic                    wr_q, wr_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [CACHE_WIDTH-1:0]  data_q, data_d;
  logic [MSG_BITS-1:0]     resp_msg_q, resp_msg_d;
  logic [ADDRESS_BITS-1:0] resp_addr_q, resp_addr_d;
  logic [CACHE_WIDTH-1:0]  resp_data_q, resp_data_d;
  logic                    is_req;
  logic                    is_wr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      resp_msg_q  <= M_NO_MSG;
      resp_addr_q <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      resp_msg_q  <= resp_msg_d;
      resp_addr_q <= resp_addr_d;
      resp_data_q <= resp_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    resp_msg_d  = resp_msg_q;
    resp_addr_d = resp_addr_q;
    resp_data_d = resp_data_q;
    is_req      = (cache2mem_msg == M_R_REQ) || (cache2mem_msg == M_WB_REQ) ||
                  (cache2mem_msg == M_FLUSH);
    is_wr       = (cache2mem_msg != M_R_REQ);

    unique case (state_q)
      IDLE: begin
        if (is_req) begin
          wr_d        = is_wr;
          addr_d      = cache2mem_address & ADDR_MASK;
          // Reads never carry line data onto the bus.
          data_d      = is_wr ? cache2mem_data : '0;
          req_valid_d = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (mem_resp_valid) begin
          resp_msg_d  = M_RESP;
          resp_addr_d = addr_q;
          resp_data_d = wr_q ? '0 : mem_resp_data;
          state_d     = RESPOND;
        end
      end
      RESPOND: begin
        if (cache2mem_msg == M_NO_REQ) begin
          resp_msg_d  = M_NO_MSG;
          resp_addr_d = '0;
          resp_data_d = '0;
          state_d     = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_req_valid     = req_valid_q;
  assign mem_req_write     = wr_q;
  assign mem_req_address   = addr_q;
  assign mem_req_data      = data_q;
  assign mem2cache_msg     = resp_msg_q;
  assign mem2cache_address = resp_addr_q;
  assign mem2cache_data    = resp_data_q;

`ifdef L1_MEM_BUS_ADAPTER_PERF_EN
  logic [31:0] perf_reads_q, perf_writes_q;
  logic        hs;

  assign hs = (state_q == ISSUE) && req_valid_q && mem_req_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_reads_q  <= '0;
      perf_writes_q <= '0;
    end else if (hs) begin
      if (wr_q) perf_writes_q <= perf_writes_q + 32'd1;
      else      perf_reads_q  <= perf_reads_q + 32'd1;
    end
  end

  assign perf_reads  = perf_reads_q;
  assign perf_writes = perf_writes_q;
`endif

endmodule

// File: tb/tb_l1_mem_bus_adapter.sv
// Directed, table-driven bench for l1_mem_bus_adapter (default parameters,
// 128-bit lines). Perf counters are checked when L1_MEM_BUS_ADAPTER_PERF_EN is set.
module tb_l1_mem_bus_adapter;

  logic          clock;
  logic          reset;
  logic [3:0]    cache2mem_msg;
  logic [31:0]   cache2mem_address;
  logic [127:0]  cache2mem_data;
  logic [3:0]    mem2cache_msg;
  logic [31:0]   mem2cache_address;
  logic [127:0]  mem2cache_data;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic          mem_req_write;
  logic [31:0]   mem_req_address;
  logic [127:0]  mem_req_data;
  logic          mem_resp_valid;
  logic [127:0]  mem_resp_data;
`ifdef L1_MEM_BUS_ADAPTER_PERF_EN
  logic [31:0]   perf_reads;
  logic [31:0]   perf_writes;
`endif

  l1_mem_bus_adapter dut (
    .clock             (clock),
    .reset             (reset),
    .cache2mem_msg     (cache2mem_msg),
    .cache2mem_address (cache2mem_address),
    .cache2mem_data    (cache2mem_data),
    .mem2cache_msg     (mem2cache_msg),
    .mem2cache_address (mem2cache_address),
    .mem2cache_data    (mem2cache_data),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_req_write     (mem_req_write),
    .mem_req_address   (mem_req_address),
    .mem_req_data      (mem_req_data),
    .mem_resp_valid    (mem_resp_valid),
    .mem_resp_data     (mem_resp_data)
`ifdef L1_MEM_BUS_ADAPTER_PERF_EN
    ,
    .perf_reads        (perf_reads),
    .perf_writes       (perf_writes)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: run time limit expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]   msg;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
    logic         exp_wr;
    logic [31:0]  exp_addr;
    logic [127:0] exp_req_data;
    logic [127:0] exp_resp_data;
  } vec_t;

  vec_t vecs[4];
  int   errors = 0;
  int   checks = 0;
  int   exp_reads = 0;
  int   exp_writes = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    cache2mem_msg     = 4'd0;
    cache2mem_address = 32'h0;
    cache2mem_data    = '0;
    mem_req_ready     = 1'b0;
    mem_resp_valid    = 1'b0;
    mem_resp_data     = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".msg"},      mem2cache_msg,     4'd0);
    chk({tag, ".maddr"},    mem2cache_address, 32'h0);
    chk({tag, ".mdata"},    mem2cache_data,    128'h0);
    chk({tag, ".valid"},    mem_req_valid,     1'b0);
    chk({tag, ".write"},    mem_req_write,     1'b0);
    chk({tag, ".raddr"},    mem_req_address,   32'h0);
    chk({tag, ".rdata"},    mem_req_data,      128'h0);
  endtask

  // Full transaction: ready=1, response one cycle after the handshake.
  task automatic do_txn(input vec_t v, input string tag);
    cache2mem_msg     = v.msg;
    cache2mem_address = v.addr;
    cache2mem_data    = v.wdata;
    mem_req_ready     = 1'b1;
    tick();
    chk({tag, ".req_valid"}, mem_req_valid,   1'b1);
    chk({tag, ".req_write"}, mem_req_write,   v.exp_wr);
    chk({tag, ".req_addr"},  mem_req_address, v.exp_addr);
    chk({tag, ".req_data"},  mem_req_data,    v.exp_req_data);
    tick();
    if (v.exp_wr) exp_writes++; else exp_reads++;
    mem_req_ready = 1'b0;
    chk({tag, ".valid_drop"}, mem_req_valid, 1'b0);
    chk({tag, ".no_early_resp"}, mem2cache_msg, 4'd0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = v.rdata;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    chk({tag, ".resp_msg"},  mem2cache_msg,     4'd4);
    chk({tag, ".resp_addr"}, mem2cache_address, v.exp_addr);
    chk({tag, ".resp_data"}, mem2cache_data,    v.exp_resp_data);
    tick();
    chk({tag, ".resp_held"}, mem2cache_msg, 4'd4);
    cache2mem_msg = 4'd0;
    tick();
    chk({tag, ".release_msg"},  mem2cache_msg,     4'd0);
    chk({tag, ".release_data"}, mem2cache_data,    128'h0);
    chk({tag, ".release_addr"}, mem2cache_address, 32'h0);
    tick();
  endtask

  initial begin
    vecs[0] = '{4'd1, 32'hEEEEEE04, 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000,
                128'h99991111_88882222_77773333_66664444,
                1'b0, 32'hEEEEEE00, 128'h0, 128'h99991111_88882222_77773333_66664444};
    vecs[1] = '{4'd2, 32'h00001234, {16{8'hA5}}, 128'h1234_5678_9ABC_DEF0_1234_5678_9ABC_DEF0,
                1'b1, 32'h00001230, {16{8'hA5}}, 128'h0};
    vecs[2] = '{4'd3, 32'hFFFFFFFF, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                128'h5555_5555_5555_5555_5555_5555_5555_5555,
                1'b1, 32'hFFFFFFF0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 128'h0};
    vecs[3] = '{4'd1, 32'h0000000F, 128'h1, 128'hCAFE_F00D_0000_0001_0000_0002_0000_0003,
                1'b0, 32'h00000000, 128'h0, 128'hCAFE_F00D_0000_0001_0000_0002_0000_0003};

    idle_inputs();
    reset = 1'b0;
    #1;
    chk_all_zero("reset");
    repeat (2) tick();
    reset = 1'b1;
    tick();

    // Unknown code and NO_REQ must not start a transaction.
    cache2mem_msg     = 4'd7;
    cache2mem_address = 32'h0000_0040;
    mem_req_ready     = 1'b1;
    repeat (3) begin
      tick();
      chk("unknown.valid", mem_req_valid, 1'b0);
    end
    idle_inputs();
    tick();

    // Reset during WAIT_RESP, then a late response is ignored.
    cache2mem_msg     = 4'd1;
    cache2mem_address = 32'h0000_0480;
    mem_req_ready     = 1'b1;
    tick();
    tick();
    mem_req_ready = 1'b0;
    cache2mem_msg = 4'd0;
    #2;
    reset = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    #2;
    reset = 1'b1;
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 128'hBAD;
    tick();
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    tick();
    chk("rst_mid.late_resp", mem2cache_msg, 4'd0);
    chk("rst_mid.no_valid",  mem_req_valid, 1'b0);

    for (int i = 0; i < 4; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

    // Backpressure on a writeback: beat stable for 5 cycles, ignored cache changes.
    cache2mem_msg     = 4'd2;
    cache2mem_address = 32'h0000_2008;
    cache2mem_data    = 128'hDEADBEEF_00112233_44556677_8899AABB;
    mem_req_ready     = 1'b0;
    tick();
    cache2mem_msg     = 4'd1;
    cache2mem_address = 32'h1111_1110;
    cache2mem_data    = 128'h0;
    for (int i = 0; i < 5; i++) begin
      chk("bp.valid", mem_req_valid,   1'b1);
      chk("bp.write", mem_req_write,   1'b1);
      chk("bp.addr",  mem_req_address, 32'h0000_2000);
      chk("bp.data",  mem_req_data,    128'hDEADBEEF_00112233_44556677_8899AABB);
      tick();
    end
    chk("bp.still_valid", mem_req_valid, 1'b1);
    mem_req_ready = 1'b1;
    tick();
    exp_writes++;
    chk("bp.valid_drop", mem_req_valid, 1'b0);
    tick();
    chk("bp.single_hs", mem_req_valid, 1'b0);
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 128'hFFFF;
    tick();
    mem_resp_valid = 1'b0;
    chk("bp.resp_msg",  mem2cache_msg,     4'd4);
    chk("bp.resp_addr", mem2cache_address, 32'h0000_2000);
    chk("bp.resp_data", mem2cache_data,    128'h0);
    cache2mem_msg = 4'd0;
    tick();
    chk("bp.release", mem2cache_msg, 4'd0);
    tick();

    // Stray responses: in IDLE and in the handshake cycle.
    idle_inputs();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 128'hABCD;
    tick();
    mem_resp_valid = 1'b0;
    tick();
    chk("stray_idle.msg", mem2cache_msg, 4'd0);
    cache2mem_msg     = 4'd1;
    cache2mem_address = 32'h0000_0100;
    mem_req_ready     = 1'b1;
    tick();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 128'h1111;
    tick();
    exp_reads++;
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b0;
    chk("stray_hs.msg0", mem2cache_msg, 4'd0);
    tick();
    chk("stray_hs.msg1", mem2cache_msg, 4'd0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 128'h2222;
    tick();
    mem_resp_valid = 1'b0;
    chk("stray_hs.resp_msg",  mem2cache_msg,  4'd4);
    chk("stray_hs.resp_data", mem2cache_data, 128'h2222);
    cache2mem_msg = 4'd0;
    tick();
    tick();

    do_txn(vecs[0], "final");

`ifdef L1_MEM_BUS_ADAPTER_PERF_EN
    chk("perf_reads",  perf_reads,  exp_reads);
    chk("perf_writes", perf_writes, exp_writes);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
